// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and constants for the Breakout game-flow controller
package game_pkg;

  typedef enum logic [2:0] {
    ST_ATTRACT = 3'd0,
    ST_SERVE   = 3'd1,
    ST_PLAY    = 3'd2,
    ST_OVER    = 3'd3,
    ST_WIN     = 3'd4
  } game_state_t;

  localparam int MAX_LIVES           = 7;
  localparam int CLK_HZ              = 50000000;
  localparam int DEFAULT_SERVE_DELAY = CLK_HZ;

  // Saturating life increment used when a cleared board awards an extra life.
  function automatic logic [2:0] lives_inc(input logic [2:0] lives);
    return (lives >= 3'(MAX_LIVES)) ? lives : lives + 3'd1;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_rise_detect.sv
// rtl/game_flow_ctrl_rise_detect.sv - registered 1-bit rising-edge detector
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
      rise_q <= sig_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - Breakout game-flow FSM: lives, serve timing, game-over handshake
// Optional macro EXTRA_LIFE_EN: a cleared board starts the next level with one extra life instead of WIN.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_LIVES   = 3,
  parameter int SERVE_DELAY = DEFAULT_SERVE_DELAY,
  parameter int CNT_W       = $clog2(SERVE_DELAY + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       ball_lost,
  input  logic       bricks_cleared,
  input  logic       game_over_complete,
  output logic       trigger_game_over,
  output logic       serve_ball,
  output logic       ball_active,
  output logic       game_reset,
  output logic [2:0] lives_left,
  output logic [2:0] game_state
);

  localparam logic [2:0] S_ATTRACT = ST_ATTRACT;
  localparam logic [2:0] S_SERVE   = ST_SERVE;
  localparam logic [2:0] S_PLAY    = ST_PLAY;
  localparam logic [2:0] S_OVER    = ST_OVER;
  localparam logic [2:0] S_WIN     = ST_WIN;

  localparam logic [2:0]       LIVES_INIT = 3'(NUM_LIVES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SERVE_DELAY - 1);

  logic start_rise;
  logic bricks_rise;

  rise_detect u_start_rise (
    .clk    (clk),
    .rst    (reset),
    .sig_i  (start_btn),
    .rise_o (start_rise)
  );

  rise_detect u_bricks_rise (
    .clk    (clk),
    .rst    (reset),
    .sig_i  (bricks_cleared),
    .rise_o (bricks_rise)
  );

  logic [2:0]       state_q, state_d;
  logic [2:0]       lives_q, lives_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             serve_q, serve_d;
  logic             trig_q, trig_d;
  logic             greset_q, greset_d;

  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    serve_d  = 1'b0;
    trig_d   = 1'b0;
    greset_d = 1'b0;
    case (state_q)
      S_ATTRACT: begin
        if (start_rise) begin
          greset_d = 1'b1;
          lives_d  = LIVES_INIT;
          cnt_d    = '0;
          state_d  = S_SERVE;
        end
      end
      S_SERVE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = S_PLAY;
          serve_d  = 1'b1;
          active_d = 1'b1;
        end
      end
      S_PLAY: begin
        active_d = 1'b1;
        // A board clear outranks a lost ball arriving on the same edge.
        if (bricks_rise) begin
          active_d = 1'b0;
          cnt_d    = '0;
`ifdef EXTRA_LIFE_EN
          greset_d = 1'b1;
          lives_d  = lives_inc(lives_q);
          state_d  = S_SERVE;
`else
          state_d  = S_WIN;
`endif
        end else if (ball_lost) begin
          active_d = 1'b0;
          if (lives_q > 3'd1) begin
            lives_d = lives_q - 3'd1;
            cnt_d   = '0;
            state_d = S_SERVE;
          end else begin
            lives_d = 3'd0;
            trig_d  = 1'b1;
            state_d = S_OVER;
          end
        end
      end
      S_OVER: begin
        if (game_over_complete) begin
          greset_d = 1'b1;
          state_d  = S_ATTRACT;
        end
      end
      S_WIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          greset_d = 1'b1;
          lives_d  = LIVES_INIT;
          state_d  = S_ATTRACT;
        end
      end
      default: begin
        state_d  = S_ATTRACT;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_ATTRACT;
      lives_q  <= LIVES_INIT;
      cnt_q    <= '0;
      active_q <= 1'b0;
      serve_q  <= 1'b0;
      trig_q   <= 1'b0;
      greset_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      serve_q  <= serve_d;
      trig_q   <= trig_d;
      greset_q <= greset_d;
    end
  end

  always @(posedge clk) begin
    if (!reset && state_q == S_PLAY && ball_lost && !bricks_rise) begin
      assert (lives_q != 3'd0);
    end
  end

  assign trigger_game_over = trig_q;
  assign serve_ball        = serve_q;
  assign ball_active       = active_q;
  assign game_reset        = greset_q;
  assign lives_left        = lives_q;
  assign game_state        = state_q;

endmodule
